// File: rtl/proc_in_fifo_pkg.sv
// Shared definitions for the processor input-port FIFO.
// Holds the status word bit positions and the read-request decode.
package proc_in_fifo_pkg;

    // Status word bit positions, also used by the firmware library
    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_UDF   = 2;
    localparam int ST_CNT   = 3;

    typedef enum logic [1:0] {
        RD_NONE  = 2'd0,
        RD_DATA  = 2'd1,
        RD_STAT  = 2'd2,
        RD_OTHER = 2'd3
    } rd_kind_e;

    function automatic rd_kind_e decode_read(input logic req,
                                             input logic is_data,
                                             input logic is_stat);
        if (!req)        return RD_NONE;
        else if (is_data) return RD_DATA;
        else if (is_stat) return RD_STAT;
        else              return RD_OTHER;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array for the input FIFO: synchronous write, asynchronous read.
module fifo_ram #(
    parameter int NUBITS = 16,
    parameter int FDEPTH = 8,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [NUBITS-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [NUBITS-1:0] rdata
);

    logic [NUBITS-1:0] mem [FDEPTH];

    // NOTE: the array has no reset; pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/proc_in_fifo.sv
// Input-port buffer between an external valid/ready producer and the processor's
// io_in/addr_in/req_in read port, with a level interrupt on a fill threshold.
module proc_in_fifo
    import proc_in_fifo_pkg::*;
#(
    parameter int NUBITS = 16,
    parameter int NBIOIN = 2,
    parameter int FDEPTH = 8,
    parameter int PDATA  = 0,
    parameter int PSTAT  = 1,
    parameter int ITHRES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUBITS-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [NBIOIN-1:0] addr_in,
    input  logic              req_in,
    output logic [NUBITS-1:0] io_in,
    output logic              itr
);

    localparam int AW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
    localparam int CW = $clog2(FDEPTH + 1);

    localparam logic [CW-1:0]     FULL_CNT   = CW'(FDEPTH);
    localparam logic [CW-1:0]     ITHRES_CNT = CW'(ITHRES);
    localparam logic [NBIOIN-1:0] ADDR_DATA  = NBIOIN'(PDATA);
    localparam logic [NBIOIN-1:0] ADDR_STAT  = NBIOIN'(PSTAT);

    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nxt;
    logic              underflow;
    logic              push;
    logic              pop;
    logic [NUBITS-1:0] rd_word;
    logic [NUBITS-1:0] status;
    rd_kind_e          rd_kind;

    fifo_ram #(
        .NUBITS (NUBITS),
        .FDEPTH (FDEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wptr),
        .wdata (s_data),
        .raddr (rptr),
        .rdata (rd_word)
    );

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        rd_kind   = decode_read(req_in, addr_in == ADDR_DATA, addr_in == ADDR_STAT);
        push      = s_valid && s_ready;
        pop       = (rd_kind == RD_DATA) && (count != '0);
        count_nxt = count + CW'(push) - CW'(pop);
    end

    // Status reflects the state before this cycle's push/pop
    always_comb begin
        status                = '0;
        status[ST_EMPTY]      = (count == '0);
        status[ST_FULL]       = (count == FULL_CNT);
        status[ST_UDF]        = underflow;
        status[ST_CNT +: CW]  = count;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            s_ready   <= 1'b1;
            itr       <= 1'b0;
            io_in     <= '0;
            underflow <= 1'b0;
        end else begin
            count   <= count_nxt;
            s_ready <= (count_nxt != FULL_CNT);
            itr     <= (count_nxt >= ITHRES_CNT);

            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);

            case (rd_kind)
                RD_DATA: begin
                    io_in <= pop ? rd_word : '0;
                    if (!pop) underflow <= 1'b1;
                end
                RD_STAT: begin
                    io_in     <= status;
                    underflow <= 1'b0;
                end
                RD_OTHER: io_in <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_in_fifo.sv
// Directed self-checking bench for proc_in_fifo (default build plus an ITHRES=2 build).
module tb_proc_in_fifo;

    localparam logic [1:0] PD = 2'd0;
    localparam logic [1:0] PS = 2'd1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic [1:0]  addr_in = '0;
    logic        req_in = 1'b0;
    logic        s_ready, itr, s_ready2, itr2;
    logic [15:0] io_in, io_in2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    proc_in_fifo dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .addr_in(addr_in), .req_in(req_in), .io_in(io_in), .itr(itr)
    );

    proc_in_fifo #(.ITHRES(2)) dut2 (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready2),
        .addr_in(addr_in), .req_in(req_in), .io_in(io_in2), .itr(itr2)
    );

    task automatic push_word(input logic [15:0] d);
        int n;
        @(negedge clk);
        s_data = d;
        s_valid = 1'b1;
        n = 0;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            checks++; failures++;
            $display("FAIL push_timeout: s_ready=%b required 1", s_ready);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic do_read(input logic [1:0] a);
        @(negedge clk);
        addr_in = a;
        req_in = 1'b1;
        @(negedge clk);
        req_in = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", s_ready); end
        checks++;
        if (io_in !== 16'h0000) begin failures++; $display("FAIL reset_io: got %h want 0000", io_in); end
        checks++;
        if (itr !== 1'b0 || itr2 !== 1'b0) begin failures++; $display("FAIL reset_itr: got %b/%b want 0/0", itr, itr2); end
        do_read(PS);
        checks++;
        if (io_in !== 16'h0001) begin failures++; $display("FAIL reset_stat: got %h want 0001", io_in); end
    endtask

    task automatic test_basic;
        logic [15:0] exp [3];
        exp[0] = 16'h0011; exp[1] = 16'h0022; exp[2] = 16'h0033;
        for (int i = 0; i < 3; i++) push_word(exp[i]);
        for (int i = 0; i < 3; i++) begin
            do_read(PD);
            checks++;
            if (io_in !== exp[i]) begin failures++; $display("FAIL basic_rd%0d: got %h want %h", i, io_in, exp[i]); end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (io_in !== 16'h0033) begin failures++; $display("FAIL basic_hold: got %h want 0033", io_in); end
        do_read(2'd2);
        checks++;
        if (io_in !== 16'h0000) begin failures++; $display("FAIL other_addr: got %h want 0000", io_in); end
    endtask

    task automatic test_full_wrap;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!s_ready) begin checks++; failures++; $display("FAIL fill_ready%0d: got 0 want 1", i); end
            s_data = 16'h0100 + 16'(i);
            s_valid = 1'b1;
        end
        @(negedge clk);
        s_valid = 1'b0;
        checks++;
        if (s_ready !== 1'b0) begin failures++; $display("FAIL full_ready: got %b want 0", s_ready); end
        do_read(PS);
        checks++;
        if (io_in !== 16'h0042) begin failures++; $display("FAIL full_stat: got %h want 0042", io_in); end
        // 9th word held while the first pop frees a slot
        @(negedge clk);
        s_data = 16'h0108;
        s_valid = 1'b1;
        addr_in = PD;
        req_in = 1'b1;
        checks++;
        if (s_ready !== 1'b0) begin failures++; $display("FAIL held_ready: got %b want 0", s_ready); end
        @(negedge clk);
        req_in = 1'b0;
        checks++;
        if (io_in !== 16'h0100) begin failures++; $display("FAIL wrap_rd0: got %h want 0100", io_in); end
        checks++;
        if (s_ready !== 1'b1) begin failures++; $display("FAIL ready_rise: got %b want 1", s_ready); end
        @(negedge clk);
        s_valid = 1'b0;
        for (int i = 1; i < 9; i++) begin
            do_read(PD);
            checks++;
            if (io_in !== 16'h0100 + 16'(i)) begin
                failures++; $display("FAIL wrap_rd%0d: got %h want %h", i, io_in, 16'h0100 + 16'(i));
            end
        end
    endtask

    task automatic test_underflow;
        do_read(PD);
        checks++;
        if (io_in !== 16'h0000) begin failures++; $display("FAIL udf_data: got %h want 0000", io_in); end
        do_read(PS);
        checks++;
        if (io_in !== 16'h0005) begin failures++; $display("FAIL udf_stat1: got %h want 0005", io_in); end
        do_read(PS);
        checks++;
        if (io_in !== 16'h0001) begin failures++; $display("FAIL udf_stat2: got %h want 0001", io_in); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) push_word(16'h00a0 + 16'(i));
        @(negedge clk);
        s_data = 16'h00a4;
        s_valid = 1'b1;
        addr_in = PD;
        req_in = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        req_in = 1'b0;
        checks++;
        if (io_in !== 16'h00a0) begin failures++; $display("FAIL simul_pop: got %h want 00a0", io_in); end
        do_read(PS);
        checks++;
        if (io_in !== 16'h0020) begin failures++; $display("FAIL simul_stat: got %h want 0020", io_in); end
        for (int i = 1; i < 5; i++) begin
            do_read(PD);
            checks++;
            if (io_in !== 16'h00a0 + 16'(i)) begin
                failures++; $display("FAIL simul_rd%0d: got %h want %h", i, io_in, 16'h00a0 + 16'(i));
            end
        end
    endtask

    task automatic test_itr;
        push_word(16'h0b01);
        checks++;
        if (itr2 !== 1'b0 || itr !== 1'b1) begin failures++; $display("FAIL itr_one: got %b/%b want 1/0", itr, itr2); end
        push_word(16'h0b02);
        checks++;
        if (itr2 !== 1'b1) begin failures++; $display("FAIL itr_two: got %b want 1", itr2); end
        do_read(PD);
        checks++;
        if (itr2 !== 1'b0 || itr !== 1'b1) begin failures++; $display("FAIL itr_pop: got %b/%b want 1/0", itr, itr2); end
        checks++;
        if (io_in !== 16'h0b01) begin failures++; $display("FAIL itr_data: got %h want 0b01", io_in); end
        do_read(PD);
        checks++;
        if (itr !== 1'b0) begin failures++; $display("FAIL itr_empty: got %b want 0", itr); end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 6; i++) push_word(16'h00c0 + 16'(i));
        do_read(PD);
        checks++;
        if (io_in !== 16'h00c0) begin failures++; $display("FAIL pre_rst_rd: got %h want 00c0", io_in); end
        @(negedge clk);
        s_data = 16'h00c6;
        s_valid = 1'b1;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (io_in !== 16'h0000) begin failures++; $display("FAIL async_io: got %h want 0000", io_in); end
        checks++;
        if (itr !== 1'b0 || itr2 !== 1'b0) begin failures++; $display("FAIL async_itr: got %b/%b want 0/0", itr, itr2); end
        @(negedge clk);
        rst = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin failures++; $display("FAIL post_rst_ready: got %b want 1", s_ready); end
        do_read(PS);
        checks++;
        if (io_in !== 16'h0001) begin failures++; $display("FAIL post_rst_stat: got %h want 0001", io_in); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_full_wrap;
        test_underflow;
        test_back_to_back;
        test_itr;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
